btn_opcode_decoder: RTL and testbench
=====================================

Name: btn_opcode_decoder

Overview:
Parametrised successor to the button-to-opcode decoder. It synchronises and debounces NUM_BTN raw push-buttons plus the active-low write button, then priority-encodes one press event into an opcode. The opcode is delivered to the ALU/register block over a valid/ready handshake, with exactly one event per physical press. It sits between the board button pins and the ALU/register-file control.

Parameters:
NUM_BTN, 5, number of operation buttons; button i maps to opcode i (0=add, 1=sub, 2=mult, 3=div, 4=prev)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before a level is accepted (>=2)
OPCODE_W, $clog2(NUM_BTN+2), opcode width; must encode NUM_BTN+1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  NUM_BTN  raw, asynchronous, active-high operation buttons
write_en_n  in  1  raw, asynchronous, active-low write button
op_ready  in  1  consumer accepts opcode when op_valid && op_ready
opcode  out  OPCODE_W  current opcode; IDLE_OP when nothing pending
op_valid  out  1  opcode holds a press event
overrun  out  1  sticky: a press was dropped while busy; cleared by reset only
btn_level  out  NUM_BTN+1  debounced levels; bit NUM_BTN = write pressed (inverted write_en_n)

Behaviour:
- Codes: OP(i)=i for buttons; WRITE_OP=NUM_BTN; IDLE_OP=NUM_BTN+1 (default 3'b110).
- Reset: opcode=IDLE_OP, op_valid=0, overrun=0, btn_level=0, all sync/debounce state 0, FSM=IDLE. Reset mid-handshake drops the pending event; no event is issued for buttons still held after reset until they are released and pressed again.
- Per input channel (NUM_BTN+1 channels, write inverted first): 2-flop synchroniser, then a debounce counter. The counter resets whenever the synchronised sample differs from the debounced level. When it reaches DEBOUNCE_CYCLES-1, the level flips. A rising edge of the debounced level is a press event.
- Latency: a raw level held stable produces op_valid high DEBOUNCE_CYCLES+3 clk edges after the first edge sampling it. Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Priority among press events in the same cycle: lowest button index wins, and WRITE_OP has lowest priority (matches the legacy order). Losers are discarded silently; this is not an overrun.
- FSM:
  - IDLE: opcode=IDLE_OP, op_valid=0. On a press event, latch the winning code, go to ISSUE.
  - ISSUE: op_valid=1; opcode stable. On op_ready, go to RELEASE the next cycle. Any new press event while in ISSUE sets overrun.
  - RELEASE: op_valid=0, opcode=IDLE_OP. Wait until all debounced levels are 0, then go to IDLE. Presses here are ignored and do not set overrun.
- op_ready while op_valid=0 has no effect. op_ready held high gives a 1-cycle op_valid pulse.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package btn_opcode_pkg: OP_ADD/OP_SUB/OP_MULT/OP_DIV/OP_PREV/OP_WRITE/OP_IDLE localparams, FSM state encoding (IDLE, ISSUE, RELEASE).
- Sub-module btn_debounce (one channel: synchroniser, counter, level, rise pulse), generated NUM_BTN+1 times.
- Top module: priority encoder, FSM, overrun flag.

Test Plan:
- Reset with btn=5'b00010 held, then release and press btn[0] for 20 cycles (DEBOUNCE_CYCLES=4, op_ready=1) -> a single op_valid pulse with opcode=0 at cycle 7 after the press; no event from the pre-reset btn[1].
- 3-cycle glitch on btn[2] -> op_valid stays 0, opcode=IDLE_OP(6).
- btn[3] and write_en_n=0 asserted together -> one event, opcode=3; write is dropped and overrun=0.
- op_ready=0 for 10 cycles after press of btn[1] -> op_valid=1, opcode=1 held stable; press btn[4] during the wait -> overrun=1; raise op_ready -> op_valid falls next cycle; no event for btn[4].
- Hold btn[0] 100 cycles with op_ready=1 -> exactly one event; release, re-press -> second event.
- Assert rst_n low while in ISSUE -> op_valid=0 and opcode=6 immediately (asynchronously); overrun cleared.

Source files
------------

// File: rtl/btn_opcode_pkg.sv
// Shared opcode constants and FSM state encoding for the button opcode decoder.
package btn_opcode_pkg;

  // Opcode values for the default five-button configuration.
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_PREV  = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;
  localparam logic [2:0] OP_IDLE  = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRelease
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level and
// a registered one-cycle rise pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [1:0]      fill_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            armed_q;
  logic            differ;
  logic            flip;

  // Level flips once the synchronised sample has disagreed for DEBOUNCE_CYCLES samples.
  always_comb begin
    differ = (sync_q[1] != level_q);
    flip   = differ && (cnt_q == CntMax);
  end

  // Synchroniser, counter, level and rise pulse. A channel only arms once its
  // synchronised input has been seen released, so buttons held through reset
  // produce no press until released and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fill_q <= {fill_q[0], 1'b1};
      if (differ) begin
        if (flip) begin
          cnt_q   <= '0;
          level_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      rise_q <= flip && !level_q && armed_q;
      if (fill_q[1] && !sync_q[1] && !level_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_opcode_decoder.sv
// Debounces the operation and write buttons, priority-encodes one press event and
// hands it to the ALU/register block over a valid/ready handshake.
module btn_opcode_decoder
  import btn_opcode_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned OPCODE_W        = $clog2(NUM_BTN + 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTN-1:0]  btn,
  input  logic                write_en_n,
  input  logic                op_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic                op_valid,
  output logic                overrun,
  output logic [NUM_BTN:0]    btn_level
);

  localparam int unsigned NumCh = NUM_BTN + 1;
  localparam logic [OPCODE_W-1:0] IdleOp = OPCODE_W'(NUM_BTN + 1);

  logic [NumCh-1:0]    raw_ch;
  logic [NumCh-1:0]    rise;
  logic                any_rise;
  logic [OPCODE_W-1:0] win_code;
  state_e              state_q;

  // The write channel sits at index NUM_BTN, so its code equals its index.
  assign raw_ch = {~write_en_n, btn};

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_ch[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  // Lowest channel index wins; scanning downwards lets the lowest overwrite last.
  always_comb begin
    any_rise = |rise;
    win_code = '0;
    for (int i = int'(NumCh) - 1; i >= 0; i--) begin
      if (rise[i]) begin
        win_code = OPCODE_W'(i);
      end
    end
  end

  // Handshake FSM with registered opcode, valid and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      opcode   <= IdleOp;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_rise) begin
            opcode   <= win_code;
            op_valid <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (any_rise) begin
            overrun <= 1'b1;
          end
          if (op_ready) begin
            opcode   <= IdleOp;
            op_valid <= 1'b0;
            state_q  <= StRelease;
          end
        end
        StRelease: begin
          if (btn_level == '0) begin
            state_q <= StIdle;
          end
        end
        default: begin
          opcode   <= IdleOp;
          op_valid <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_opcode_decoder.sv
// Directed bench with a scoreboard: stimulus pushes expected opcodes, a monitor
// pops and compares on every accepted transfer.
module tb_btn_opcode_decoder;
  import btn_opcode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  logic       write_en_n;
  logic       op_ready;
  logic [2:0] opcode;
  logic       op_valid;
  logic       overrun;
  logic [5:0] btn_level;

  int unsigned exp_q[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;

  btn_opcode_decoder #(
    .NUM_BTN        (5),
    .DEBOUNCE_CYCLES(4),
    .OPCODE_W       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .write_en_n(write_en_n),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .op_valid  (op_valid),
    .overrun   (overrun),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer must match the oldest expected opcode.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && op_valid && op_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(opcode), 32'(OP_IDLE));
          n_bad += (opcode == OP_IDLE) ? 1 : 0;
          if (opcode == OP_IDLE) $display("FAIL unexpected_event: got valid expected none");
        end else begin
          check("sb_opcode", 32'(opcode), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int seen;
    int x0;
    rst_n      = 1'b0;
    btn        = 5'b00010;
    write_en_n = 1'b1;
    op_ready   = 1'b1;
    repeat (3) tick();
    check("rst_opcode", 32'(opcode), 32'(OP_IDLE));
    check("rst_valid", 32'(op_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);

    // btn[1] held through reset: level follows, but no event.
    rst_n = 1'b1;
    repeat (12) tick();
    check("held_level", 32'(btn_level), 32'b000010);
    check("held_no_valid", 32'(op_valid), 32'd0);

    // Release btn[1], press btn[0]: op_valid on the 7th edge.
    btn = 5'b00001;
    exp_q.push_back(32'(OP_ADD));
    repeat (6) tick();
    check("lat_early", 32'(op_valid), 32'd0);
    tick();
    check("lat_valid", 32'(op_valid), 32'd1);
    check("lat_opcode", 32'(opcode), 32'(OP_ADD));
    repeat (13) tick();
    btn = '0;
    repeat (12) tick();
    check("post_add_valid", 32'(op_valid), 32'd0);
    check("post_add_opcode", 32'(opcode), 32'(OP_IDLE));
    check("post_add_level", 32'(btn_level), 32'd0);

    // Glitch one cycle shorter than the debounce window.
    btn = 5'b00100;
    repeat (3) tick();
    btn = '0;
    seen = 0;
    repeat (12) begin
      tick();
      if (op_valid) seen = 1;
    end
    check("glitch_valid", 32'(seen), 32'd0);
    check("glitch_opcode", 32'(opcode), 32'(OP_IDLE));

    // btn[3] and write together: div wins, write dropped without overrun.
    btn        = 5'b01000;
    write_en_n = 1'b0;
    exp_q.push_back(32'(OP_DIV));
    repeat (10) tick();
    btn        = '0;
    write_en_n = 1'b1;
    repeat (12) tick();
    check("prio_overrun", 32'(overrun), 32'd0);
    check("prio_level", 32'(btn_level), 32'd0);

    // Stalled consumer: opcode held, second press sets overrun.
    op_ready = 1'b0;
    btn      = 5'b00010;
    exp_q.push_back(32'(OP_SUB));
    repeat (7) tick();
    check("stall_valid", 32'(op_valid), 32'd1);
    check("stall_opcode", 32'(opcode), 32'(OP_SUB));
    btn = 5'b10010;
    repeat (8) tick();
    check("stall_valid2", 32'(op_valid), 32'd1);
    check("stall_opcode2", 32'(opcode), 32'(OP_SUB));
    check("stall_overrun", 32'(overrun), 32'd1);
    op_ready = 1'b1;
    tick();
    check("accept_valid", 32'(op_valid), 32'd0);
    btn = '0;
    repeat (12) tick();
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("after_stall_opcode", 32'(opcode), 32'(OP_IDLE));

    // Long hold gives one event; re-press gives another.
    x0 = n_xfer;
    btn = 5'b00001;
    exp_q.push_back(32'(OP_ADD));
    repeat (100) tick();
    check("hold_one_event", 32'(n_xfer - x0), 32'd1);
    btn = '0;
    repeat (12) tick();
    btn = 5'b00001;
    exp_q.push_back(32'(OP_ADD));
    repeat (10) tick();
    check("repress_event", 32'(n_xfer - x0), 32'd2);
    btn = '0;
    repeat (12) tick();

    // Asynchronous reset while issuing drops the event.
    op_ready = 1'b0;
    btn      = 5'b00100;
    repeat (8) tick();
    check("issue_valid", 32'(op_valid), 32'd1);
    check("issue_opcode", 32'(opcode), 32'(OP_MULT));
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(op_valid), 32'd0);
    check("arst_opcode", 32'(opcode), 32'(OP_IDLE));
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_level", 32'(btn_level), 32'd0);
    btn      = '0;
    op_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("final_valid", 32'(op_valid), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
